// File: rtl/fifo_write_ctrl.sv
// Write-side controller for a synchronous FIFO: gates producer writes against
// full, registers the RAM write port and tracks occupancy plus sticky error flags.
module fifo_write_ctrl #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned AW       = 4,
  parameter int unsigned AFULL_TH = 12
) (
  input  logic              i_clk,
  input  logic              i_rest,
  input  logic              i_flush,
  input  logic              i_wen,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_ren_ctrl,
  input  logic              i_clr_err,
  output logic              o_wen_ctrl,
  output logic [AW-1:0]     o_waddr,
  output logic [DATA_W-1:0] o_wdata,
  output logic              o_full,
  output logic              o_afull,
  output logic [AW:0]       o_count,
  output logic              o_overflow,
  output logic              o_underflow
);

  localparam logic [AW:0] C_DEPTH = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] C_AFULL = AFULL_TH[AW:0];

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_PART  = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [AW:0]       r_count;
  logic [AW:0]       w_count_nxt;
  logic [AW-1:0]     r_wptr;
  logic              r_wen;
  logic [AW-1:0]     r_waddr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_ovf;
  logic              r_udf;
  logic              w_full;
  logic              w_wr_acc;
  logic              w_rd_acc;
  logic              w_ovf_set;
  logic              w_udf_set;

  assign w_full    = (r_state == S_FULL);
  assign w_wr_acc  = i_wen && !w_full && !i_flush;
  assign w_rd_acc  = i_ren_ctrl && (r_count != '0) && !i_flush;
  assign w_ovf_set = i_wen && w_full && !i_flush;
  assign w_udf_set = i_ren_ctrl && (r_count == '0) && !i_flush;

  always_comb begin
    w_count_nxt = r_count;
    if (i_flush) begin
      w_count_nxt = '0;
    end else begin
      case ({w_wr_acc, w_rd_acc})
        2'b10:   w_count_nxt = r_count + 1'b1;
        2'b01:   w_count_nxt = r_count - 1'b1;
        default: w_count_nxt = r_count;
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (i_flush) begin
      w_state_nxt = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: if (w_wr_acc) w_state_nxt = S_PART;
        S_PART: begin
          if (w_count_nxt == '0)          w_state_nxt = S_EMPTY;
          else if (w_count_nxt == C_DEPTH) w_state_nxt = S_FULL;
        end
        S_FULL:  if (w_rd_acc) w_state_nxt = S_PART;
        default: w_state_nxt = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rest) begin
    if (!i_rest) begin
      r_state <= S_EMPTY;
      r_count <= '0;
      r_wptr  <= '0;
      r_wen   <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_wen   <= w_wr_acc;
      if (i_flush) begin
        r_wptr <= '0;
      end else if (w_wr_acc) begin
        r_waddr <= r_wptr;
        r_wdata <= i_wdata;
        r_wptr  <= r_wptr + 1'b1;
      end
      // A new error in the same cycle as a clear keeps the flag set.
      if (w_ovf_set)      r_ovf <= 1'b1;
      else if (i_clr_err) r_ovf <= 1'b0;
      if (w_udf_set)      r_udf <= 1'b1;
      else if (i_clr_err) r_udf <= 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rest) begin
      assert ((r_state == S_EMPTY && r_count == '0) ||
              (r_state == S_FULL  && r_count == C_DEPTH) ||
              (r_state == S_PART  && r_count != '0 && r_count < C_DEPTH));
    end
  end

  assign o_wen_ctrl  = r_wen;
  assign o_waddr     = r_waddr;
  assign o_wdata     = r_wdata;
  assign o_full      = w_full;
  assign o_afull     = (r_count >= C_AFULL);
  assign o_count     = r_count;
  assign o_overflow  = r_ovf;
  assign o_underflow = r_udf;

endmodule
